// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer.
//   constants : machine-wide widths (OPCODE_SIZE).
//   opcodes   : opcode map, op-class and FSM state enums, opcode classifier.

package constants;
  localparam int OPCODE_SIZE = 5;
endpackage

package opcodes;
  import constants::*;

  typedef logic [OPCODE_SIZE-1:0] opcode_t;

  // Control opcodes; 0x00-0x0F are ALU operations, 0x17-0x1D are unassigned.
  localparam opcode_t OPC_LD   = 5'h10;
  localparam opcode_t OPC_ST   = 5'h11;
  localparam opcode_t OPC_JMP  = 5'h12;
  localparam opcode_t OPC_BEQ  = 5'h13;
  localparam opcode_t OPC_BNE  = 5'h14;
  localparam opcode_t OPC_CALL = 5'h15;
  localparam opcode_t OPC_RET  = 5'h16;
  localparam opcode_t OPC_NOP  = 5'h1E;
  localparam opcode_t OPC_HALT = 5'h1F;

  // ALU function used to form a load/store address.
  localparam logic [3:0] ALU_ADDR_ADD = 4'h0;

  typedef enum logic [3:0] {
    OP_ALU  = 4'd0,
    OP_LD   = 4'd1,
    OP_ST   = 4'd2,
    OP_JMP  = 4'd3,
    OP_BEQ  = 4'd4,
    OP_BNE  = 4'd5,
    OP_CALL = 4'd6,
    OP_RET  = 4'd7,
    OP_NOP  = 4'd8,
    OP_HALT = 4'd9,
    OP_ILL  = 4'd10
  } op_class_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } state_e;

  // Map an opcode onto the execution class the sequencer acts on.
  function automatic op_class_e classify(input opcode_t opc);
    op_class_e cls;
    cls = OP_ILL;
    if (opc[OPCODE_SIZE-1] == 1'b0) begin
      cls = OP_ALU;
    end else begin
      case (opc)
        OPC_LD:   cls = OP_LD;
        OPC_ST:   cls = OP_ST;
        OPC_JMP:  cls = OP_JMP;
        OPC_BEQ:  cls = OP_BEQ;
        OPC_BNE:  cls = OP_BNE;
        OPC_CALL: cls = OP_CALL;
        OPC_RET:  cls = OP_RET;
        OPC_NOP:  cls = OP_NOP;
        OPC_HALT: cls = OP_HALT;
        default:  cls = OP_ILL;
      endcase
    end
    return cls;
  endfunction

  // States in which a memory request is outstanding.
  function automatic logic is_req_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction
endpackage

// File: rtl/cpu_sequencer_watchdog.sv
// Bus-timeout watchdog for the sequencer's memory handshakes.
// Counts cycles a request waits without ack; raises a combinational
// timeout in the last allowed cycle if ack is still absent, so an ack
// in that same cycle always wins. MEM_TIMEOUT = 0 disables it.

module seq_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = &{clk, reset, clear, req, ack};
      assign timeout = 1'b0;
    end else begin : g_enabled
      localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
      localparam logic [CW-1:0] ONE  = CW'(1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Next count: restart on entry to a request state, count unanswered wait cycles.
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (req && !ack && (cnt_q != LAST)) begin
          cnt_d = cnt_q + ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Wait-cycle counter register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign timeout = req & ~ack & (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 19-bit CPU: fetch, decode, execute,
// memory and writeback, with imem/dmem req/ack handshakes and a bus
// watchdog. Strobes decode from the state register (plus the ack in
// handshake cycles), so an asynchronous reset clears them immediately.
// Optional: define CPU_SEQ_PERF_CNT_EN to add the instr_retired counter.

module cpu_sequencer
  import opcodes::*;
#(
  parameter int OPCODE_SIZE = constants::OPCODE_SIZE,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   zero_flag,
  output logic                   imem_req,
  input  logic                   imem_ack,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   pc_src,
  output logic                   stack_push,
  output logic                   stack_pop,
  output logic                   alu_en,
  output logic [3:0]             alu_op,
  output logic                   reg_we,
  output logic                   wb_sel,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal_op,
  output logic                   bus_error
`ifdef CPU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]            instr_retired
`endif
);

  state_e    state_q, state_d;
  op_class_e class_q, class_d;
  logic [3:0] alu_fn_q, alu_fn_d;
  logic      illegal_q, illegal_d;
  logic      bus_err_q, bus_err_d;

  logic       imem_req_s, dmem_req_s, dmem_we_s, ir_load_s, pc_inc_s;
  logic       pc_load_s, pc_src_s, stack_push_s, stack_pop_s, alu_en_s;
  logic [3:0] alu_op_s;
  logic       reg_we_s, wb_sel_s, retire_s;
  state_e     boundary_s;

  logic wd_clear_s, wd_req_s, wd_ack_s, wd_timeout_s;

  // The watchdog sees whichever handshake the current state owns.
  assign wd_req_s   = is_req_state(state_q);
  assign wd_ack_s   = (state_q == ST_FETCH) ? imem_ack :
                      ((state_q == ST_MEM) ? dmem_ack : 1'b0);
  assign wd_clear_s = (state_d != state_q) && is_req_state(state_d);

  seq_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear_s),
    .req     (wd_req_s),
    .ack     (wd_ack_s),
    .timeout (wd_timeout_s)
  );

  // Next-state and strobe decode; run only matters at instruction boundaries.
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    alu_fn_d     = alu_fn_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    ir_load_s    = 1'b0;
    pc_inc_s     = 1'b0;
    pc_load_s    = 1'b0;
    pc_src_s     = 1'b0;
    stack_push_s = 1'b0;
    stack_pop_s  = 1'b0;
    alu_en_s     = 1'b0;
    alu_op_s     = 4'h0;
    reg_we_s     = 1'b0;
    wb_sel_s     = 1'b0;
    retire_s     = 1'b0;
    boundary_s   = run ? ST_FETCH : ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_load_s = 1'b1;
          pc_inc_s  = 1'b1;
          state_d   = ST_DECODE;
        end else if (wd_timeout_s) begin
          bus_err_d = 1'b1;
          state_d   = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        class_d  = classify(opcode);
        alu_fn_d = opcode[3:0];
        state_d  = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (class_q)
          OP_ALU: begin
            alu_en_s = 1'b1;
            alu_op_s = alu_fn_q;
            state_d  = ST_WB;
          end
          OP_LD, OP_ST: begin
            alu_en_s = 1'b1;
            alu_op_s = ALU_ADDR_ADD;
            state_d  = ST_MEM;
          end
          OP_JMP: begin
            pc_load_s = 1'b1;
            retire_s  = 1'b1;
            state_d   = boundary_s;
          end
          OP_BEQ: begin
            pc_load_s = zero_flag;
            retire_s  = 1'b1;
            state_d   = boundary_s;
          end
          OP_BNE: begin
            pc_load_s = ~zero_flag;
            retire_s  = 1'b1;
            state_d   = boundary_s;
          end
          OP_CALL: begin
            stack_push_s = 1'b1;
            pc_load_s    = 1'b1;
            retire_s     = 1'b1;
            state_d      = boundary_s;
          end
          OP_RET: begin
            stack_pop_s = 1'b1;
            pc_load_s   = 1'b1;
            pc_src_s    = 1'b1;
            retire_s    = 1'b1;
            state_d     = boundary_s;
          end
          OP_NOP: begin
            retire_s = 1'b1;
            state_d  = boundary_s;
          end
          OP_HALT: begin
            retire_s = 1'b1;
            state_d  = ST_HALT;
          end
          OP_ILL: begin
            illegal_d = 1'b1;
            state_d   = ST_FAULT;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_FAULT;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (class_q == OP_ST);
        if (dmem_ack) begin
          if (class_q == OP_ST) begin
            retire_s = 1'b1;
            state_d  = boundary_s;
          end else begin
            state_d = ST_WB;
          end
        end else if (wd_timeout_s) begin
          bus_err_d = 1'b1;
          state_d   = ST_FAULT;
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_WB: begin
        reg_we_s = 1'b1;
        wb_sel_s = (class_q == OP_LD);
        retire_s = 1'b1;
        state_d  = boundary_s;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State, latched op class and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      class_q   <= OP_NOP;
      alu_fn_q  <= 4'h0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      alu_fn_q  <= alu_fn_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign imem_req   = imem_req_s;
  assign dmem_req   = dmem_req_s;
  assign dmem_we    = dmem_we_s;
  assign ir_load    = ir_load_s;
  assign pc_inc     = pc_inc_s;
  assign pc_load    = pc_load_s;
  assign pc_src     = pc_src_s;
  assign stack_push = stack_push_s;
  assign stack_pop  = stack_pop_s;
  assign alu_en     = alu_en_s;
  assign alu_op     = alu_op_s;
  assign reg_we     = reg_we_s;
  assign wb_sel     = wb_sel_s;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_FAULT);
  assign halted     = (state_q == ST_HALT);
  assign illegal_op = illegal_q;
  assign bus_error  = bus_err_q;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Retired-instruction count; wraps naturally at 2^32.
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign instr_retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire_s;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a cycle-by-cycle vector table
// for the main instruction flow plus hand-written multi-cycle sequences
// (watchdog, illegal/halt, asynchronous reset, run boundary, perf counter).

module tb_cpu_sequencer;

  localparam logic [15:0] E_IREQ   = 16'h0001;
  localparam logic [15:0] E_DREQ   = 16'h0002;
  localparam logic [15:0] E_DWE    = 16'h0004;
  localparam logic [15:0] E_IRL    = 16'h0008;
  localparam logic [15:0] E_PCI    = 16'h0010;
  localparam logic [15:0] E_PCL    = 16'h0020;
  localparam logic [15:0] E_PSRC   = 16'h0040;
  localparam logic [15:0] E_PUSH   = 16'h0080;
  localparam logic [15:0] E_POP    = 16'h0100;
  localparam logic [15:0] E_ALUEN  = 16'h0200;
  localparam logic [15:0] E_REGWE  = 16'h0400;
  localparam logic [15:0] E_WBSEL  = 16'h0800;
  localparam logic [15:0] E_BUSY   = 16'h1000;
  localparam logic [15:0] E_HALTED = 16'h2000;
  localparam logic [15:0] E_ILL    = 16'h4000;
  localparam logic [15:0] E_BERR   = 16'h8000;
  localparam logic [15:0] FA = E_IREQ | E_IRL | E_PCI | E_BUSY;
  localparam logic [15:0] FW = E_IREQ | E_BUSY;
  localparam logic [15:0] B  = E_BUSY;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [4:0] opcode = 5'h00;
  logic       zero_flag = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, pc_src;
  logic       stack_push, stack_pop, alu_en, reg_we, wb_sel, busy, halted;
  logic       illegal_op, bus_error;
  logic [3:0] alu_op;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] instr_retired;
`endif

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(
    .OPCODE_SIZE (5),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_src     (pc_src),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .busy       (busy),
    .halted     (halted),
    .illegal_op (illegal_op),
    .bus_error  (bus_error)
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    .instr_retired (instr_retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [4:0]  opc;
    logic        zf;
    logic        iack;
    logic        dack;
    logic [15:0] exp;
    logic [3:0]  aop;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] outs();
    return {bus_error, illegal_op, halted, busy, wb_sel, reg_we, alu_en, stack_pop,
            stack_push, pc_src, pc_load, pc_inc, ir_load, dmem_we, dmem_req, imem_req};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [4:0] o, input logic z, input logic ia,
                     input logic da, input logic [15:0] e, input logic [3:0] a);
    vec_t v;
    v.run = r; v.opc = o; v.zf = z; v.iack = ia; v.dack = da; v.exp = e; v.aop = a;
    vecs.push_back(v);
  endtask

  // Hold reset, check every output is zero, release at a falling edge.
  task automatic do_reset();
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero_flag = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {12'h000, alu_op, outs()}, 32'h0);
`ifdef CPU_SEQ_PERF_CNT_EN
    check("reset_retired", instr_retired, 32'd0);
`endif
    reset = 1'b1;
  endtask

  // Advance to the next sample point (1 time unit after the falling edge).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [4:0] opc);
    opcode = opc;
    for (int k = 0; k < 12; k++) begin
      step();
      if (imem_req || !busy) break;
    end
  endtask

  initial begin
    int cnt;
    int bad;

    // ---------------- Main flow table ----------------
    add(1, 5'h03, 0, 0, 0, 16'h0, 4'h0);            // IDLE
    add(1, 5'h03, 0, 1, 0, FA, 4'h0);               // FETCH ack
    add(1, 5'h03, 0, 0, 0, B, 4'h0);                // DECODE
    add(1, 5'h03, 0, 0, 0, B | E_ALUEN, 4'h3);      // EXECUTE ALU
    add(1, 5'h03, 0, 0, 0, B | E_REGWE, 4'h0);      // WB
    add(1, 5'h10, 0, 1, 0, FA, 4'h0);               // LD fetch
    add(1, 5'h10, 0, 0, 0, B, 4'h0);
    add(1, 5'h10, 0, 0, 0, B | E_ALUEN, 4'h0);
    add(1, 5'h10, 0, 0, 0, B | E_DREQ, 4'h0);
    add(1, 5'h10, 0, 0, 0, B | E_DREQ, 4'h0);
    add(1, 5'h10, 0, 0, 0, B | E_DREQ, 4'h0);
    add(1, 5'h10, 0, 0, 1, B | E_DREQ, 4'h0);       // dmem_ack after 3 waits
    add(1, 5'h10, 0, 0, 0, B | E_REGWE | E_WBSEL, 4'h0);
    add(1, 5'h11, 0, 1, 0, FA, 4'h0);               // ST
    add(1, 5'h11, 0, 0, 0, B, 4'h0);
    add(1, 5'h11, 0, 0, 0, B | E_ALUEN, 4'h0);
    add(1, 5'h11, 0, 0, 1, B | E_DREQ | E_DWE, 4'h0);
    add(1, 5'h13, 0, 1, 0, FA, 4'h0);               // BEQ zf=0
    add(1, 5'h13, 0, 0, 0, B, 4'h0);
    add(1, 5'h13, 0, 0, 0, B, 4'h0);
    add(1, 5'h13, 1, 1, 0, FA, 4'h0);               // BEQ zf=1
    add(1, 5'h13, 1, 0, 0, B, 4'h0);
    add(1, 5'h13, 1, 0, 0, B | E_PCL, 4'h0);
    add(1, 5'h14, 1, 1, 0, FA, 4'h0);               // BNE zf=1
    add(1, 5'h14, 1, 0, 0, B, 4'h0);
    add(1, 5'h14, 1, 0, 0, B, 4'h0);
    add(1, 5'h14, 0, 1, 0, FA, 4'h0);               // BNE zf=0
    add(1, 5'h14, 0, 0, 0, B, 4'h0);
    add(1, 5'h14, 0, 0, 0, B | E_PCL, 4'h0);
    add(1, 5'h16, 0, 1, 0, FA, 4'h0);               // RET
    add(1, 5'h16, 0, 0, 0, B, 4'h0);
    add(1, 5'h16, 0, 0, 0, B | E_POP | E_PCL | E_PSRC, 4'h0);
    add(1, 5'h15, 0, 1, 0, FA, 4'h0);               // CALL
    add(1, 5'h15, 0, 0, 0, B, 4'h0);
    add(1, 5'h15, 0, 0, 0, B | E_PUSH | E_PCL, 4'h0);
    add(1, 5'h12, 0, 0, 0, FW, 4'h0);               // JMP, one fetch wait
    add(1, 5'h12, 0, 1, 0, FA, 4'h0);
    add(1, 5'h12, 0, 0, 0, B, 4'h0);
    add(1, 5'h12, 0, 0, 0, B | E_PCL, 4'h0);
    add(1, 5'h1E, 0, 1, 0, FA, 4'h0);               // NOP
    add(1, 5'h1E, 0, 0, 0, B, 4'h0);
    add(0, 5'h1E, 0, 0, 0, B, 4'h0);                // run=0 at boundary
    add(0, 5'h1E, 0, 0, 0, 16'h0, 4'h0);            // IDLE
    add(0, 5'h0F, 0, 0, 0, 16'h0, 4'h0);
    add(1, 5'h0F, 0, 0, 0, 16'h0, 4'h0);            // IDLE -> FETCH
    add(1, 5'h0F, 0, 1, 0, FA, 4'h0);
    add(1, 5'h0F, 0, 0, 0, B, 4'h0);
    add(1, 5'h0F, 0, 0, 0, B | E_ALUEN, 4'hF);
    add(0, 5'h0F, 0, 0, 0, B | E_REGWE, 4'h0);      // WB -> IDLE
    add(0, 5'h0F, 0, 0, 0, 16'h0, 4'h0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      run = vecs[i].run; opcode = vecs[i].opc; zero_flag = vecs[i].zf;
      imem_ack = vecs[i].iack; dmem_ack = vecs[i].dack;
      #1;
      check($sformatf("vec%0d", i), {12'h000, alu_op, outs()}, {12'h000, vecs[i].aop, vecs[i].exp});
    end

    // ---------------- Fetch timeout: imem_ack never arrives ----------------
    do_reset();
    run = 1'b1; opcode = 5'h1E;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_req) cnt++;
      else if (cnt > 0) break;
    end
    check("timeout_req_cycles", cnt, 15);
    check("timeout_fault", outs(), E_BERR);
    repeat (3) step();
    check("timeout_terminal", outs(), E_BERR);

    // ---------------- Ack in the 15th (last allowed) cycle ----------------
    do_reset();
    run = 1'b1; opcode = 5'h1E;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (outs() != FW) bad++;
    end
    check("lastack_wait_cycles", bad, 0);
    @(negedge clk); imem_ack = 1'b1; #1;
    check("lastack_accept", outs(), FA);
    @(negedge clk); imem_ack = 1'b0; #1;
    check("lastack_decode", outs(), B);
    step();
    step();
    check("lastack_next_fetch", outs(), FW);

    // ---------------- Data-memory timeout ----------------
    do_reset();
    run = 1'b1; opcode = 5'h10; imem_ack = 1'b1;
    step(); step(); step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dmem_req) cnt++;
      else break;
    end
    check("dmem_timeout_cycles", cnt, 15);
    check("dmem_timeout_fault", outs(), E_BERR);

    // ---------------- Illegal opcode ----------------
    do_reset();
    run = 1'b1; opcode = 5'h18; imem_ack = 1'b1;
    step();
    check("ill_fetch", outs(), FA);
    step();
    step();
    check("ill_execute", {12'h000, alu_op, outs()}, {16'h0000, B});
    step();
    check("ill_fault", outs(), E_ILL);
    step();
    check("ill_terminal", outs(), E_ILL);

    // ---------------- HALT ----------------
    do_reset();
    run = 1'b1; opcode = 5'h1F; imem_ack = 1'b1;
    step(); step(); step();
    check("halt_execute", outs(), B);
    step();
    check("halt_state", outs(), E_HALTED);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (outs() != E_HALTED) bad++;
    end
    check("halt_terminal", bad, 0);

    // ---------------- Asynchronous reset while in MEM ----------------
    do_reset();
    run = 1'b1; opcode = 5'h10; imem_ack = 1'b1;
    step(); step(); step(); step();
    check("arst_in_mem", outs(), B | E_DREQ);
    #2 reset = 1'b0;
    #1;
    check("arst_dreq_drop", {12'h000, alu_op, outs()}, 32'h0);

    // ---------------- run dropped mid-LD ----------------
    do_reset();
    run = 1'b1; opcode = 5'h10; imem_ack = 1'b1;
    step(); step(); step();
    step();
    run = 1'b0;
    check("runlow_mem", outs(), B | E_DREQ);
    @(negedge clk); dmem_ack = 1'b1; #1;
    check("runlow_mem_ack", outs(), B | E_DREQ);
    @(negedge clk); dmem_ack = 1'b0; #1;
    check("runlow_wb", outs(), B | E_REGWE | E_WBSEL);
    step();
    check("runlow_idle", outs(), 16'h0);
    step();
    check("runlow_stay_idle", outs(), 16'h0);
`ifdef CPU_SEQ_PERF_CNT_EN
    check("runlow_retired", instr_retired, 32'd1);
`endif

    // ---------------- Ten mixed instructions then HALT ----------------
    do_reset();
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    step();
    check("mix_first_fetch", outs(), FA);
    do_instr(5'h01); do_instr(5'h10); do_instr(5'h11); do_instr(5'h12);
    do_instr(5'h13); do_instr(5'h14); do_instr(5'h15); do_instr(5'h16);
    do_instr(5'h1E); do_instr(5'h07); do_instr(5'h1F);
    check("mix_halted", outs(), E_HALTED);
`ifdef CPU_SEQ_PERF_CNT_EN
    check("mix_retired", instr_retired, 32'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
